// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED activity stretcher.
// Defaults target the 12 MHz board: 1 ms hold tick, 50 ms hold.
package led_pkg;

    localparam int unsigned TICK_DIV_DEF   = 12000;
    localparam int unsigned HOLD_TICKS_DEF = 50;

    // Bits needed to count 0..v-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    typedef logic [clog2(HOLD_TICKS_DEF + 1)-1:0] hold_def_t;

endpackage

// File: rtl/led_stretch_cell.sv
// One LED's hold counter: reloads on any input change, counts down on
// prescaler ticks and saturates at zero.
module led_stretch_cell
    import led_pkg::*;
#(
    parameter int unsigned pHoldTicks = HOLD_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in_bit,
    input  logic prev_bit,
    output logic lit,
    output logic busy
);

    localparam int unsigned   HW        = clog2(pHoldTicks + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(pHoldTicks);

    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          chg;

    // A change reloads even when a tick lands in the same cycle.
    always_comb begin
        chg    = in_bit ^ prev_bit;
        hold_d = hold_q;
        if (chg) begin
            hold_d = HOLD_LOAD;
        end else if (tick && (hold_q != '0)) begin
            hold_d = hold_q - HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign busy = (hold_q != '0);
    assign lit  = in_bit | busy;

endmodule

// File: rtl/led_stretch_pwm.sv
// Stretches single-cycle bus events into human-visible LED pulses and
// dims all LED pins with a global PWM brightness setting.
module led_stretch_pwm
    import led_pkg::*;
#(
    parameter int unsigned pLeds      = 8,
    parameter int unsigned pTickDiv   = TICK_DIV_DEF,
    parameter int unsigned pHoldTicks = HOLD_TICKS_DEF,
    parameter int unsigned pPwmBits   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [pLeds-1:0]    blinkenlights,
    input  logic [pPwmBits-1:0] brightness,
    output logic [pLeds-1:0]    leds,
    output logic                activity
);

    localparam int unsigned   TW        = clog2(pTickDiv);
    localparam logic [TW-1:0] TICK_LAST = TW'(pTickDiv - 1);

    logic [1:0]          rst_sync_q;
    logic                rst_n_sync;
    logic [pLeds-1:0]    prev_q;
    logic [TW-1:0]       tick_cnt_q;
    logic [TW-1:0]       tick_cnt_d;
    logic                tick;
    logic [pPwmBits-1:0] pwm_cnt_q;
    logic [pPwmBits-1:0] pwm_cnt_d;
    logic [pPwmBits-1:0] bright_q;
    logic [pPwmBits-1:0] bright_d;
    logic                pwm_on;
    logic [pLeds-1:0]    lit;
    logic [pLeds-1:0]    busy;
    logic [pLeds-1:0]    leds_q;
    logic [pLeds-1:0]    leds_d;
    logic                activity_q;
    logic                activity_d;

    // Assert passes straight through; release waits two clk edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_sync = rst_sync_q[1];

    for (genvar gi = 0; gi < pLeds; gi++) begin : g_cell
        led_stretch_cell #(
            .pHoldTicks(pHoldTicks)
        ) u_cell (
            .clk     (clk),
            .rst     (rst_n_sync),
            .tick    (tick),
            .in_bit  (blinkenlights[gi]),
            .prev_bit(prev_q[gi]),
            .lit     (lit[gi]),
            .busy    (busy[gi])
        );
    end

    // Brightness is only sampled at PWM count 0 so a period is never split.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        pwm_cnt_d  = pwm_cnt_q + pPwmBits'(1);
        bright_d   = (pwm_cnt_q == '0) ? brightness : bright_q;
        pwm_on     = (&bright_q) | (pwm_cnt_q < bright_q);
        leds_d     = lit & {pLeds{pwm_on}};
        activity_d = |busy;
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            prev_q     <= '0;
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            bright_q   <= '0;
            leds_q     <= '0;
            activity_q <= 1'b0;
        end else begin
            prev_q     <= blinkenlights;
            tick_cnt_q <= tick_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            bright_q   <= bright_d;
            leds_q     <= leds_d;
            activity_q <= activity_d;
        end
    end

    assign leds     = leds_q;
    assign activity = activity_q;

endmodule
